// File: rtl/au_dispatch_pkg.sv
// Shared definitions for the AU dispatcher: datapath defaults, opcodes,
// FSM state encoding and a sign-magnitude helper.
package au_dispatch_pkg;

    localparam int AU_W    = 24;  // sign bit + 23-bit magnitude
    localparam int AU_FRAC = 14;  // Q9.14

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_EXT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_WB    = 2'b11
    } state_t;

    // Collapse negative zero to positive zero so the register file only ever holds +0.
    function automatic logic [AU_W-1:0] sm_norm(input logic [AU_W-1:0] v);
        logic [AU_W-1:0] r;
        if (v[AU_W-2:0] == {(AU_W-1){1'b0}}) begin
            r = {AU_W{1'b0}};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/au_dispatch_if.sv
// Instruction handshake and AU operand/result bus. The slave modport is the
// dispatcher; the master modport is the upstream/AU environment.
interface au_dispatch_if #(
    parameter int AW = 4,
    parameter int W  = 24
);
    logic          instr_valid;
    logic          instr_ready;
    logic [1:0]    instr_op;
    logic [AW-1:0] instr_dst;
    logic [AW-1:0] instr_src1;
    logic [AW-1:0] instr_src2;
    logic [W-1:0]  instr_imm;

    logic          au_start;
    logic [W-1:0]  au_R;
    logic [W-1:0]  au_S;
    logic [W-1:0]  au_I;
    logic [1:0]    au_ctl_d;
    logic [W-1:0]  au_result;
    logic          au_done;
    logic          au_busy;

    modport slave (
        input  instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm,
        output instr_ready,
        output au_start, au_R, au_S, au_I, au_ctl_d,
        input  au_result, au_done, au_busy
    );

    modport master (
        output instr_valid, instr_op, instr_dst, instr_src1, instr_src2, instr_imm,
        input  instr_ready,
        input  au_start, au_R, au_S, au_I, au_ctl_d,
        output au_result, au_done, au_busy
    );
endinterface

// File: rtl/au_regfile.sv
// NREG x W register file: two operand read ports, one host read port,
// write-back and host write ports (write-back wins on an address clash), r0 hard-zero.
module au_regfile #(
    parameter int NREG = 16,
    parameter int W    = 24,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] rah,
    output logic [W-1:0]  rd1,
    output logic [W-1:0]  rd2,
    output logic [W-1:0]  rdh,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [W-1:0]  wb_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data
);

    logic [W-1:0] rf_q [NREG];
    logic [W-1:0] rf_d [NREG];

    // Next register contents: write-back over host write, r0 pinned to +0.
    always_comb begin
        rf_d[0] = {W{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            if (wb_en && (wb_addr == AW'(i))) begin
                rf_d[i] = wb_data;
            end else if (ld_en && (ld_addr == AW'(i))) begin
                rf_d[i] = ld_data;
            end else begin
                rf_d[i] = rf_q[i];
            end
        end
    end

    // Register storage, cleared to +0 on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign rd1 = rf_q[ra1];
    assign rd2 = rf_q[ra2];
    assign rdh = rf_q[rah];

endmodule

// File: rtl/au_dispatch.sv
// Issue stage in front of the AU: accepts one instruction at a time, latches
// operands from the register file, starts the AU, waits for done and writes back.
// Optional WAIT timeout with sticky err flag: define AU_DISPATCH_TIMEOUT_EN.
module au_dispatch
    import au_dispatch_pkg::*;
#(
    parameter int W       = AU_W,
    parameter int NREG    = 16,
    parameter int TIMEOUT = 64,
    parameter int AW      = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    au_dispatch_if.slave  bus,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          idle,
    output logic [15:0]   op_cnt,
    output logic          err,
    input  logic          err_clr
);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [W-1:0]  r_q, r_d, s_q, s_d, i_q, i_d, res_q, res_d;
    logic          start_q, start_d;
    logic          idle_q, idle_d;
    logic [15:0]   op_cnt_q, op_cnt_d;
    logic          err_q, err_d;

    logic          instr_ready_s;
    logic          accept_s;
    logic          done_in_wait_s;
    logic          timeout_s;
    logic          wb_en_s;
    logic [W-1:0]  wb_data_s;
    logic [W-1:0]  rd1_s, rd2_s;

    assign instr_ready_s  = idle_q && !bus.au_busy;
    assign accept_s       = bus.instr_valid && instr_ready_s;
    assign done_in_wait_s = (state_q == S_WAIT) && bus.au_done;

`ifdef AU_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] tcnt_q, tcnt_d;

    assign timeout_s = (state_q == S_WAIT) && !bus.au_done && (tcnt_q == TW'(TIMEOUT - 1));

    // WAIT cycle counter; it sits at zero outside WAIT so every entry starts fresh.
    always_comb begin
        if (state_q == S_WAIT) begin
            tcnt_d = tcnt_q + TW'(1);
        end else begin
            tcnt_d = {TW{1'b0}};
        end
    end

    // WAIT cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= {TW{1'b0}};
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
    assign timeout_s = 1'b0;
`endif

    au_regfile #(.NREG(NREG), .W(W), .AW(AW)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra1     (bus.instr_src1),
        .ra2     (bus.instr_src2),
        .rah     (rd_addr),
        .rd1     (rd1_s),
        .rd2     (rd2_s),
        .rdh     (rd_data),
        .wb_en   (wb_en_s),
        .wb_addr (dst_q),
        .wb_data (wb_data_s),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE -> ISSUE -> WAIT -> WB -> IDLE, with optional WAIT abort.
    always_comb begin
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.au_done) begin
                    state_d = S_WB;
                end else if (timeout_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values: operand capture, result capture, counters, err.
    always_comb begin
        if (accept_s) begin
            op_d  = bus.instr_op;
            dst_d = bus.instr_dst;
            r_d   = rd1_s;
            s_d   = rd2_s;
            i_d   = bus.instr_imm;
        end else begin
            op_d  = op_q;
            dst_d = dst_q;
            r_d   = r_q;
            s_d   = s_q;
            i_d   = i_q;
        end

        if (done_in_wait_s) begin
            res_d = bus.au_result;
        end else begin
            res_d = res_q;
        end

        start_d = accept_s;
        idle_d  = (state_d == S_IDLE);
        wb_en_s = (state_q == S_WB);
        wb_data_s = sm_norm(res_q);

        if (state_q == S_WB) begin
            op_cnt_d = op_cnt_q + 16'd1;
        end else begin
            op_cnt_d = op_cnt_q;
        end

`ifdef AU_DISPATCH_TIMEOUT_EN
        if (timeout_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
`else
        err_d = err_q & ~err_clr;
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 2'b00;
            dst_q    <= {AW{1'b0}};
            r_q      <= {W{1'b0}};
            s_q      <= {W{1'b0}};
            i_q      <= {W{1'b0}};
            res_q    <= {W{1'b0}};
            start_q  <= 1'b0;
            idle_q   <= 1'b1;
            op_cnt_q <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            dst_q    <= dst_d;
            r_q      <= r_d;
            s_q      <= s_d;
            i_q      <= i_d;
            res_q    <= res_d;
            start_q  <= start_d;
            idle_q   <= idle_d;
            op_cnt_q <= op_cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.instr_ready = instr_ready_s;
    assign bus.au_start    = start_q;
    assign bus.au_R        = r_q;
    assign bus.au_S        = s_q;
    assign bus.au_I        = i_q;
    assign bus.au_ctl_d    = op_q;
    assign idle            = idle_q;
    assign op_cnt          = op_cnt_q;
    assign err             = err_q;

endmodule

// File: tb/tb_au_dispatch.sv
// Bench for au_dispatch: a behavioural AU stub (done two cycles after start),
// a cycle-level model of the dispatcher built from its rules, a per-cycle
// compare process, and directed scenarios with literal expectations.
module tb_au_dispatch;
    import au_dispatch_pkg::*;

    localparam int W = 24, AW = 4, NREG = 16, TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    au_dispatch_if #(.AW(AW), .W(W)) bus ();

    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = 4'd0;
    logic [W-1:0]  ld_data = 24'd0;
    logic [AW-1:0] rd_addr = 4'd0;
    logic [W-1:0]  rd_data;
    logic          idle, err;
    logic          err_clr = 1'b0;
    logic [15:0]   op_cnt;

    au_dispatch #(.W(W), .NREG(NREG), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .idle(idle), .op_cnt(op_cnt), .err(err), .err_clr(err_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- sign-magnitude Q9.14 arithmetic ----------------
    function automatic longint sm2i(input logic [23:0] v);
        longint m;
        m = longint'(v[22:0]);
        return v[23] ? -m : m;
    endfunction

    function automatic logic [23:0] i2sm(input longint v);
        longint a;
        a = (v < 0) ? -v : v;
        if (a > 64'h7FFFFF) a = 64'h7FFFFF;
        return {(v < 0), a[22:0]};
    endfunction

    function automatic logic [23:0] alu(input logic [1:0] op, input logic [23:0] r,
                                        input logic [23:0] s, input logic [23:0] i);
        longint x, y, z, q;
        x = sm2i(r); y = sm2i(s); z = sm2i(i);
        case (op)
            2'b00:   q = x + y;
            2'b01:   q = x - y;
            2'b10:   q = (x * y) / 16384;
            default: q = x + z;
        endcase
        return i2sm(q);
    endfunction

    // ---------------- AU stub ----------------
    logic never_done = 1'b0;
    logic spur_done  = 1'b0;
    logic d1;
    initial bus.au_busy = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= 1'b0;
            bus.au_done <= 1'b0;
            bus.au_result <= 24'd0;
        end else begin
            d1 <= bus.au_start;
            bus.au_done <= (d1 && !never_done) || spur_done;
            if (bus.au_start) begin
                logic [23:0] r;
                r = alu(bus.au_ctl_d, bus.au_R, bus.au_S, bus.au_I);
                if (bus.au_ctl_d == OP_SUB && r[22:0] == 23'd0) r[23] = 1'b1; // AU yields -0
                bus.au_result <= r;
            end
        end
    end

    // ---------------- dispatcher model ----------------
    int          cyc, acc_c, op_cnt_m;
    logic        pend, m_stuck, err_m, wb, tmo;
    logic [1:0]  m_op;
    logic [3:0]  m_dst;
    logic [23:0] m_r, m_s, m_i, m_res;
    logic [23:0] rf_m [16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; pend = 1'b0; op_cnt_m = 0; err_m = 1'b0; acc_c = 0;
            for (int k = 0; k < 16; k++) rf_m[k] = 24'd0;
        end else begin
            wb = 1'b0; tmo = 1'b0;
            if (!pend && bus.instr_valid && !bus.au_busy) begin
                m_op = bus.instr_op; m_dst = bus.instr_dst; m_i = bus.instr_imm;
                m_r = rf_m[bus.instr_src1]; m_s = rf_m[bus.instr_src2];
                m_res = alu(m_op, m_r, m_s, m_i);
                m_stuck = never_done; pend = 1'b1; acc_c = cyc;
            end else if (pend && !m_stuck && cyc == acc_c + 4) begin
                wb = 1'b1;
            end else if (pend && m_stuck && cyc == acc_c + 1 + TO) begin
`ifdef AU_DISPATCH_TIMEOUT_EN
                tmo = 1'b1;
`endif
            end
            if (ld_en && ld_addr != 4'd0) rf_m[ld_addr] = ld_data;
            if (wb) begin
                if (m_dst != 4'd0) rf_m[m_dst] = m_res;
                op_cnt_m = (op_cnt_m + 1) & 16'hFFFF;
                pend = 1'b0;
            end
            if (tmo) begin
                pend = 1'b0; err_m = 1'b1;
            end else if (err_clr) begin
                err_m = 1'b0;
            end
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic run_chk = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (rst_n && run_chk) begin
            chk("idle", {31'd0, idle}, {31'd0, !pend});
            chk("instr_ready", {31'd0, bus.instr_ready}, {31'd0, !pend && !bus.au_busy});
            chk("op_cnt", {16'd0, op_cnt}, op_cnt_m);
            chk("err", {31'd0, err}, {31'd0, err_m});
            chk("rd_data", {8'd0, rd_data}, {8'd0, rf_m[rd_addr]});
            chk("au_start", {31'd0, bus.au_start}, {31'd0, pend && cyc == acc_c + 1});
            if (pend && cyc > acc_c) begin
                chk("au_R", {8'd0, bus.au_R}, {8'd0, m_r});
                chk("au_S", {8'd0, bus.au_S}, {8'd0, m_s});
                chk("au_I", {8'd0, bus.au_I}, {8'd0, m_i});
                chk("au_ctl_d", {30'd0, bus.au_ctl_d}, {30'd0, m_op});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [1:0] op, input logic [3:0] d, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [23:0] imm);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!bus.instr_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL issue_wait: ready never rose, got 0 expected 1");
        end
        bus.instr_valid = 1'b1; bus.instr_op = op; bus.instr_dst = d;
        bus.instr_src1 = s1; bus.instr_src2 = s2; bus.instr_imm = imm;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!idle && n < 60) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL wait_idle: idle got 0 expected 1");
        end
    endtask

    task automatic ld(input logic [3:0] a, input logic [23:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic lit_rd(input string nm, input logic [3:0] a, input logic [23:0] e);
        @(negedge clk);
        rd_addr = a;
        #1;
        chk(nm, {8'd0, rd_data}, {8'd0, e});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        bus.instr_valid = 1'b0; bus.instr_op = 2'b00; bus.instr_dst = 4'd0;
        bus.instr_src1 = 4'd0; bus.instr_src2 = 4'd0; bus.instr_imm = 24'd0;

        // Reset state
        repeat (3) @(negedge clk);
        rd_addr = 4'd1; #1;
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("rst_op_cnt", {16'd0, op_cnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_start", {31'd0, bus.au_start}, 32'd0);
        chk("rst_rf", {8'd0, rd_data}, 32'd0);
        @(negedge clk); rst_n = 1'b1; run_chk = 1'b1;

        // 1: ADD r3 = 3.0 + -2.0, accept-to-ready latency
        ld(4'd1, 24'h00C000);
        ld(4'd2, 24'h808000);
        issue(OP_ADD, 4'd3, 4'd1, 4'd2, 24'd0);
        lat = 1;
        while (!bus.instr_ready && lat < 40) begin
            @(negedge clk); #1; lat++;
        end
        chk("ready_latency", lat, 32'd5);
        lit_rd("add_r3", 4'd3, 24'h004000);
        chk("op_cnt_1", {16'd0, op_cnt}, 32'd1);

        // 2: MUL and SUB with -0 normalisation
        issue(OP_MUL, 4'd4, 4'd2, 4'd2, 24'd0); wait_idle();
        lit_rd("mul_r4", 4'd4, 24'h010000);
        issue(OP_SUB, 4'd5, 4'd1, 4'd1, 24'd0); wait_idle();
        lit_rd("sub_r5", 4'd5, 24'h000000);

        // 3: writes to r0 dropped, count still advances
        issue(OP_ADD, 4'd0, 4'd1, 4'd1, 24'd0); wait_idle();
        lit_rd("wb_r0", 4'd0, 24'h000000);
        chk("op_cnt_4", {16'd0, op_cnt}, 32'd4);
        ld(4'd0, 24'h123456);
        lit_rd("ld_r0", 4'd0, 24'h000000);

        // 4a: host write and WB to r3 in the same cycle, WB wins
        issue(OP_ADD, 4'd3, 4'd1, 4'd1, 24'd0);
        repeat (3) @(negedge clk);
        ld_en = 1'b1; ld_addr = 4'd3; ld_data = 24'h01C000;
        @(negedge clk); ld_en = 1'b0;
        lit_rd("wb_wins_r3", 4'd3, 24'h018000);

        // 4b: host write r6 during WB to r7, both land
        issue(OP_ADD, 4'd7, 4'd1, 4'd2, 24'd0);
        repeat (3) @(negedge clk);
        ld_en = 1'b1; ld_addr = 4'd6; ld_data = 24'h01C000;
        @(negedge clk); ld_en = 1'b0;
        lit_rd("ld_r6", 4'd6, 24'h01C000);
        lit_rd("wb_r7", 4'd7, 24'h004000);

        // 4c: host write to r1 one cycle after accept does not disturb operands
        issue(OP_ADD, 4'd8, 4'd1, 4'd1, 24'd0);
        ld_en = 1'b1; ld_addr = 4'd1; ld_data = 24'h004000;
        @(negedge clk); ld_en = 1'b0;
        wait_idle();
        lit_rd("old_r1_r8", 4'd8, 24'h018000);
        lit_rd("new_r1", 4'd1, 24'h004000);

        // AU busy blocks ready; stray done in IDLE is ignored
        @(negedge clk); bus.au_busy = 1'b1; #1;
        chk("busy_ready", {31'd0, bus.instr_ready}, 32'd0);
        @(negedge clk); bus.au_busy = 1'b0;
        spur_done = 1'b1;
        @(negedge clk); spur_done = 1'b0;
        repeat (3) @(negedge clk); #1;
        chk("spur_op_cnt", {16'd0, op_cnt}, 32'd7);
        chk("spur_idle", {31'd0, idle}, 32'd1);

        // Multi-cycle op slot: r9 = r1 + imm = 1.0 + 3.0
        issue(OP_EXT, 4'd9, 4'd1, 4'd0, 24'h00C000); wait_idle();
        lit_rd("ext_r9", 4'd9, 24'h010000);

        // 5: AU never completes
        never_done = 1'b1;
        issue(OP_ADD, 4'd10, 4'd1, 4'd1, 24'd0);
        repeat (12) @(negedge clk); #1;
`ifdef AU_DISPATCH_TIMEOUT_EN
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_idle", {31'd0, idle}, 32'd1);
        chk("tmo_op_cnt", {16'd0, op_cnt}, 32'd8);
        lit_rd("tmo_r10", 4'd10, 24'h000000);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; #1;
        chk("err_clr", {31'd0, err}, 32'd0);
        issue(OP_ADD, 4'd10, 4'd1, 4'd1, 24'd0);
        err_clr = 1'b1;
        repeat (9) @(negedge clk); #1;
        chk("clr_vs_tmo", {31'd0, err}, 32'd1);
        err_clr = 1'b0;
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        issue(OP_ADD, 4'd11, 4'd1, 4'd1, 24'd0);
`else
        chk("stuck_idle", {31'd0, idle}, 32'd0);
        chk("stuck_err", {31'd0, err}, 32'd0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; #1;
        chk("stuck_err_clr", {31'd0, err}, 32'd0);
`endif

        // 6: asynchronous reset in WAIT
        repeat (2) @(negedge clk);
        run_chk = 1'b0;
        rd_addr = 4'd1;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_idle", {31'd0, idle}, 32'd1);
        chk("arst_op_cnt", {16'd0, op_cnt}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        chk("arst_rf_r1", {8'd0, rd_data}, 32'd0);
        chk("arst_au_R", {8'd0, bus.au_R}, 32'd0);
        chk("arst_start", {31'd0, bus.au_start}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
